mm_array_feeder: RTL and testbench
==================================

Name: mm_array_feeder

Overview:
- Control stage directly upstream of the `memory_array` shift-buffer of the accelerator.
- Accepts a stream of 32-bit words over a valid/ready handshake and writes them row by row into the array, using the array's load, one-hot select and data inputs.
- Once a full MM_HGT x MM_WDT tile is held, it drains the tile column by column to the downstream compute stage, using the array's shift enable and a valid/ready column handshake.
- Counts completed tiles.

Parameters:
- MM_HGT, `MM_HGT (shared parameters header): number of array rows.
- MM_WDT, `MM_WDT (shared parameters header): words per row, and columns per tile.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous abort; discards the current tile's progress.
- s_data  input  32  input word.
- s_valid  input  1  input word valid.
- s_ready  output  1  feeder accepts a word this cycle.
- mm_load  output  1  to array load.
- mm_enable  output  1  to array enable (column shift).
- mm_sel  output  MM_HGT  to array sel; bit 0 is row 0 (MSB-first vector [0:MM_HGT-1]).
- mm_data  output  32  to array data.
- mm_result  input  MM_HGT*32  from array result (last column of every row).
- col_data  output  MM_HGT*32  column presented downstream; equals mm_result.
- col_valid  output  1  col_data valid.
- col_last  output  1  final column of the tile.
- col_ready  input  1  downstream accepts the column.
- tile_done  output  1  one-cycle pulse after a tile fully drains.
- tile_count  output  16  number of tiles drained; wraps at 65535 -> 0.

Behaviour:
- Two states: LOAD and STREAM.
- Reset (asynchronous): state=LOAD, row=0, word=0, col=0, tile_done=0, tile_count=0.
- During reset all outputs are 0 except s_ready=1 (LOAD state).
- LOAD state:
  - s_ready=1, col_valid=0, mm_enable=0.
  - mm_load = s_valid & s_ready; mm_data = s_data (combinational, zero latency).
  - mm_sel = one-hot(row) when mm_load, else all-zero.
  - Each accepted word increments word. When word==MM_WDT-1, word wraps to 0 and row increments.
  - Acceptance of word (row=MM_HGT-1, word=MM_WDT-1): row wraps to 0 and state moves to STREAM on the next edge.
  - The array already holds the full tile at that edge.
- Data ordering: the array shifts loads toward index 0. After a row loads words w0..w(W-1), position l holds w_l.
- STREAM state:
  - s_ready=0, mm_load=0, mm_sel=0, col_valid=1, col_data=mm_result.
  - col_last=(col==MM_WDT-1).
  - Column k presented = word w(W-1-k) of every row, so the first column is the last-loaded word.
  - On col_valid & col_ready with !col_last: mm_enable=1 for that cycle (combinational), col increments.
  - On col_valid & col_ready with col_last: mm_enable=0, col goes to 0, state goes to LOAD, tile_count increments.
  - tile_done is a registered 1-cycle pulse in the following cycle.
- Per tile: exactly MM_WDT-1 enable pulses. mm_load and mm_enable are never both 1.
- Backpressure: col_ready=0 holds col, col_data is stable, and mm_enable=0.
- MM_WDT==1: the only column is last; no enable pulses are issued.
- Flush (sync, highest priority after reset):
  - Forces state=LOAD and row=word=col=0. mm_load, mm_enable and col_valid are 0 in the flush cycle.
  - tile_count is unchanged and no tile_done pulse is issued.
  - Array contents are not cleared; stale data is fully overwritten by the next complete load (every row shifts MM_WDT times).
- Reset mid-STREAM or mid-LOAD returns to the reset state immediately. The array shares the reset, so both are consistent.
- Counter widths: row uses $clog2(MM_HGT), word and col use $clog2(MM_WDT), each a minimum of 1 bit.

Decomposition:
- Shared parameters header (existing): MM_HGT, MM_WDT defaults.
- Feeder package or local localparams: state encoding (LOAD=0, STREAM=1) and counter widths.
- One natural sub-module: `onehot_dec` (row index -> MM_HGT one-hot with enable), reusable by other row-select logic.
- The bench instantiates mm_array_feeder connected to memory_array.

Test Plan:
- H=2, W=3: stream words 1..6 with s_valid always high.
  - Required: 6 loads with sel=10,10,10,01,01,01.
  - Then col_data = {3,6}, {2,5}, {1,4}; col_last on the third column; tile_done 1 cycle later; tile_count=1.
- Same tile with col_ready low for 4 cycles on column 2.
  - Required: col_data held at {2,5}, mm_enable=0 throughout the stall; completion is unchanged after the stall.
- s_valid toggling 1,0,1,0.
  - Required: only the accepted words increment counters; the tile result is identical to the first scenario.
- flush after 4 words, then load words 11..16.
  - Required: columns {13,16}, {12,15}, {11,14}; tile_count is unchanged by the flush.
- reset asserted during STREAM column 1.
  - Required: s_ready=1, col_valid=0, tile_count=0 immediately (asynchronously); next tile loads cleanly.
- Drain 65536 tiles (small H=1, W=1).
  - Required: tile_count wraps to 0; each tile gives exactly one col_valid cycle and 0 enables.

Source files
------------

// File: rtl/mm_array_feeder_pkg.sv
// Shared definitions for the memory-array feeder: array geometry defaults,
// FSM state encoding and counter width helper.
package mm_array_feeder_pkg;

    localparam int unsigned MM_HGT_DEF = 2;
    localparam int unsigned MM_WDT_DEF = 3;

    typedef enum logic {
        LOAD   = 1'b0,
        STREAM = 1'b1
    } feeder_state_t;

    // Index counters never collapse to zero width, even for a 1-entry dimension.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mm_array_feeder_onehot_dec.sv
// Row index to one-hot row select with enable; bit 0 of the
// MSB-first vector selects row 0.
module onehot_dec #(
    parameter int unsigned N  = 2,
    parameter int unsigned IW = 1
) (
    input  logic          en,
    input  logic [IW-1:0] idx,
    output logic [0:N-1]  onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (idx == IW'(i)) onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mm_array_feeder.sv
// Loads a tile row by row into the memory_array shift-buffer, then drains it
// column by column downstream over a valid/ready handshake.
module mm_array_feeder
    import mm_array_feeder_pkg::*;
#(
    parameter int unsigned MM_HGT = MM_HGT_DEF,
    parameter int unsigned MM_WDT = MM_WDT_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic [31:0]          s_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    output logic                 mm_load,
    output logic                 mm_enable,
    output logic [0:MM_HGT-1]    mm_sel,
    output logic [31:0]          mm_data,
    input  logic [MM_HGT*32-1:0] mm_result,
    output logic [MM_HGT*32-1:0] col_data,
    output logic                 col_valid,
    output logic                 col_last,
    input  logic                 col_ready,
    output logic                 tile_done,
    output logic [15:0]          tile_count
);

    localparam int unsigned RW = cnt_width(MM_HGT);
    localparam int unsigned CW = cnt_width(MM_WDT);
    localparam logic [RW-1:0] ROW_LAST = RW'(MM_HGT - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(MM_WDT - 1);

    feeder_state_t state, state_d;
    logic [RW-1:0] row;
    logic [CW-1:0] word;
    logic [CW-1:0] col;

    // Flush suppresses every handshake in its cycle, including s_ready.
    always_comb begin
        state_d   = state;
        s_ready   = 1'b0;
        mm_load   = 1'b0;
        mm_data   = '0;
        mm_enable = 1'b0;
        col_valid = 1'b0;
        col_last  = 1'b0;
        if (flush) begin
            state_d = LOAD;
        end else begin
            case (state)
                LOAD: begin
                    s_ready = 1'b1;
                    mm_load = s_valid;
                    mm_data = s_data;
                    if (s_valid && word == COL_LAST && row == ROW_LAST) state_d = STREAM;
                end
                STREAM: begin
                    col_valid = 1'b1;
                    col_last  = (col == COL_LAST);
                    mm_enable = col_ready & ~col_last;
                    if (col_ready && col_last) state_d = LOAD;
                end
                default: state_d = LOAD;
            endcase
        end
    end

    assign col_data = mm_result;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= LOAD;
        else       state <= state_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row        <= '0;
            word       <= '0;
            col        <= '0;
            tile_done  <= 1'b0;
            tile_count <= '0;
        end else begin
            tile_done <= 1'b0;
            if (flush) begin
                row  <= '0;
                word <= '0;
                col  <= '0;
            end else begin
                if (mm_load) begin
                    if (word == COL_LAST) begin
                        word <= '0;
                        row  <= (row == ROW_LAST) ? '0 : row + 1'b1;
                    end else begin
                        word <= word + 1'b1;
                    end
                end
                if (col_valid && col_ready) begin
                    if (col_last) begin
                        col        <= '0;
                        tile_count <= tile_count + 16'd1;
                        tile_done  <= 1'b1;
                    end else begin
                        col <= col + 1'b1;
                    end
                end
            end
        end
    end

    onehot_dec #(.N(MM_HGT), .IW(RW)) u_row_dec (
        .en     (mm_load),
        .idx    (row),
        .onehot (mm_sel)
    );

endmodule

// File: tb/tb_mm_array_feeder.sv
// Self-checking bench for mm_array_feeder with a behavioural memory_array
// model; expected columns come from the word list each tile was built from.
`timescale 1ns/1ps
module tb_mm_array_feeder;

    localparam int H = 2;
    localparam int W = 3;

    logic clk = 1'b0;
    logic clk_s = 1'b0;
    always #5 clk = ~clk;
    always #2 clk_s = ~clk_s;

    logic           reset, flush, s_valid, s_ready, col_ready;
    logic [31:0]    s_data, mm_data;
    logic           mm_load, mm_enable, col_valid, col_last, tile_done;
    logic [0:H-1]   mm_sel;
    logic [H*32-1:0] mm_result, col_data;
    logic [15:0]    tile_count;

    logic           sm_flush, sm_valid, sm_ready_o, sm_col_ready;
    logic [31:0]    sm_data, sm_mdata, sm_result, sm_col_data;
    logic           sm_load, sm_enable, sm_col_valid, sm_col_last, sm_tile_done;
    logic [0:0]     sm_sel;
    logic [15:0]    sm_tile_count;

    mm_array_feeder #(.MM_HGT(H), .MM_WDT(W)) u_dut (
        .clk(clk), .reset(reset), .flush(flush),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .mm_load(mm_load), .mm_enable(mm_enable), .mm_sel(mm_sel), .mm_data(mm_data),
        .mm_result(mm_result), .col_data(col_data), .col_valid(col_valid),
        .col_last(col_last), .col_ready(col_ready),
        .tile_done(tile_done), .tile_count(tile_count)
    );

    mm_array_feeder #(.MM_HGT(1), .MM_WDT(1)) u_small (
        .clk(clk_s), .reset(reset), .flush(sm_flush),
        .s_data(sm_data), .s_valid(sm_valid), .s_ready(sm_ready_o),
        .mm_load(sm_load), .mm_enable(sm_enable), .mm_sel(sm_sel), .mm_data(sm_mdata),
        .mm_result(sm_result), .col_data(sm_col_data), .col_valid(sm_col_valid),
        .col_last(sm_col_last), .col_ready(sm_col_ready),
        .tile_done(sm_tile_done), .tile_count(sm_tile_count)
    );

    // memory_array model: loads shift toward index 0, enables shift toward W-1,
    // result is index W-1 of every row with row 0 in the top word.
    logic [31:0] arr [H][W];
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < H; r++)
                for (int l = 0; l < W; l++) arr[r][l] <= '0;
        end else begin
            for (int r = 0; r < H; r++) begin
                if (mm_load && mm_sel[r]) begin
                    for (int l = 0; l < W - 1; l++) arr[r][l] <= arr[r][l+1];
                    arr[r][W-1] <= mm_data;
                end else if (mm_enable) begin
                    for (int l = W - 1; l > 0; l--) arr[r][l] <= arr[r][l-1];
                    arr[r][0] <= '0;
                end
            end
        end
    end
    always_comb begin
        mm_result = '0;
        for (int r = 0; r < H; r++) mm_result[(H-1-r)*32 +: 32] = arr[r][W-1];
    end

    logic [31:0] sm_arr;
    always @(posedge clk_s or posedge reset) begin
        if (reset) sm_arr <= '0;
        else if (sm_load && sm_sel[0]) sm_arr <= sm_mdata;
    end
    assign sm_result = sm_arr;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] tw [H*W];
    int          acc = 0;
    logic [15:0] exp_count = '0;

    function automatic logic [H*32-1:0] exp_col(input int k);
        logic [H*32-1:0] v = '0;
        for (int r = 0; r < H; r++) v[(H-1-r)*32 +: 32] = tw[r*W + (W-1-k)];
        return v;
    endfunction

    function automatic logic [0:H-1] exp_sel(input int r);
        logic [0:H-1] v = '0;
        v[r] = 1'b1;
        return v;
    endfunction

    // mode 0: valid always high, 1: alternating 1,0,..., 2: random
    task automatic load_words(input int n, input int mode);
        int sent = 0;
        int k = 0;
        logic v;
        while (sent < n) begin
            if (k > 200) begin
                n_checks++; n_fail++;
                $display("FAIL load_timeout: sent %0d words, expected %0d", sent, n);
                break;
            end
            @(posedge clk); #1;
            v = (mode == 0) ? 1'b1 : (mode == 1) ? ((k % 2) == 0) : 1'($urandom_range(0, 1));
            s_valid = v;
            s_data  = v ? tw[acc] : $urandom;
            k++;
            @(negedge clk);
            n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL load_s_ready: got %b expected 1", s_ready); end
            n_checks++; if (mm_load !== v) begin n_fail++; $display("FAIL load_mm_load: got %b expected %b", mm_load, v); end
            n_checks++; if (mm_sel !== (v ? exp_sel(acc / W) : '0)) begin n_fail++; $display("FAIL load_mm_sel: got %b expected %b (word %0d)", mm_sel, v ? exp_sel(acc / W) : '0, acc); end
            n_checks++; if ({mm_enable, col_valid} !== 2'b00) begin n_fail++; $display("FAIL load_idle_outputs: enable/col_valid got %b%b expected 00", mm_enable, col_valid); end
            if (v) begin
                n_checks++; if (mm_data !== tw[acc]) begin n_fail++; $display("FAIL load_mm_data: got %h expected %h", mm_data, tw[acc]); end
                acc++; sent++;
            end
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic drain(input int stall_col, input int stall_n, input bit rnd);
        int ns;
        for (int k = 0; k < W; k++) begin
            ns = rnd ? int'($urandom_range(0, 2)) : ((k == stall_col) ? stall_n : 0);
            col_ready = 1'b0;
            repeat (ns) begin
                @(negedge clk);
                n_checks++; if (col_valid !== 1'b1) begin n_fail++; $display("FAIL stall_col_valid: got %b expected 1", col_valid); end
                n_checks++; if (col_data !== exp_col(k)) begin n_fail++; $display("FAIL stall_col_data: got %h expected %h", col_data, exp_col(k)); end
                n_checks++; if (mm_enable !== 1'b0) begin n_fail++; $display("FAIL stall_mm_enable: got %b expected 0", mm_enable); end
                @(posedge clk); #1;
            end
            col_ready = 1'b1;
            @(negedge clk);
            n_checks++; if (col_valid !== 1'b1) begin n_fail++; $display("FAIL col_valid: got %b expected 1 (col %0d)", col_valid, k); end
            n_checks++; if (col_data !== exp_col(k)) begin n_fail++; $display("FAIL col_data: got %h expected %h (col %0d)", col_data, exp_col(k), k); end
            n_checks++; if (col_last !== (k == W - 1)) begin n_fail++; $display("FAIL col_last: got %b expected %b (col %0d)", col_last, k == W - 1, k); end
            n_checks++; if (mm_enable !== (k != W - 1)) begin n_fail++; $display("FAIL col_mm_enable: got %b expected %b (col %0d)", mm_enable, k != W - 1, k); end
            n_checks++; if ({s_ready, mm_load, tile_done} !== 3'b000) begin n_fail++; $display("FAIL stream_quiet: ready/load/done got %b%b%b expected 000", s_ready, mm_load, tile_done); end
            @(posedge clk); #1;
        end
        col_ready = 1'b0;
        exp_count++;
        acc = 0;
        @(negedge clk);
        n_checks++; if (tile_done !== 1'b1) begin n_fail++; $display("FAIL tile_done_pulse: got %b expected 1", tile_done); end
        n_checks++; if (tile_count !== exp_count) begin n_fail++; $display("FAIL tile_count: got %0d expected %0d", tile_count, exp_count); end
        n_checks++; if ({col_valid, s_ready} !== 2'b01) begin n_fail++; $display("FAIL back_to_load: col_valid/s_ready got %b%b expected 01", col_valid, s_ready); end
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++; if (tile_done !== 1'b0) begin n_fail++; $display("FAIL tile_done_width: got %b expected 0", tile_done); end
    endtask

    task automatic fill_seq(input int base);
        for (int i = 0; i < H*W; i++) tw[i] = 32'(base + i);
    endtask

    task automatic fill_rand();
        for (int i = 0; i < H*W; i++) tw[i] = $urandom;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; s_valid = 1'b0; s_data = '0; col_ready = 1'b0;
        sm_flush = 1'b0; sm_valid = 1'b0; sm_data = '0; sm_col_ready = 1'b0;
        #3;
        n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL reset_s_ready: got %b expected 1", s_ready); end
        n_checks++; if ({mm_load, mm_enable, col_valid, col_last, tile_done} !== 5'b0) begin n_fail++; $display("FAIL reset_controls: got %b expected 00000", {mm_load, mm_enable, col_valid, col_last, tile_done}); end
        n_checks++; if (mm_sel !== '0) begin n_fail++; $display("FAIL reset_mm_sel: got %b expected 00", mm_sel); end
        n_checks++; if (tile_count !== 16'd0) begin n_fail++; $display("FAIL reset_tile_count: got %0d expected 0", tile_count); end
        n_checks++; if ({col_data, mm_data} !== '0) begin n_fail++; $display("FAIL reset_data: col_data %h mm_data %h expected 0", col_data, mm_data); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic();
        fill_seq(1); acc = 0;
        load_words(H*W, 0);
        drain(-1, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        fill_seq(1); acc = 0;
        load_words(H*W, 0);
        drain(1, 4, 1'b0);
    endtask

    task automatic test_valid_toggle();
        fill_seq(1); acc = 0;
        load_words(H*W, 1);
        drain(-1, 0, 1'b0);
    endtask

    task automatic test_flush();
        fill_rand(); acc = 0;
        load_words(4, 0);
        @(posedge clk); #1;
        flush = 1'b1; s_valid = 1'b1; s_data = 32'hdead_beef;
        @(negedge clk);
        n_checks++; if ({mm_load, mm_enable, col_valid} !== 3'b000) begin n_fail++; $display("FAIL flush_load_quiet: load/enable/valid got %b%b%b expected 000", mm_load, mm_enable, col_valid); end
        @(posedge clk); #1;
        flush = 1'b0; s_valid = 1'b0;
        @(negedge clk);
        n_checks++; if ({tile_done, tile_count} !== {1'b0, exp_count}) begin n_fail++; $display("FAIL flush_count: done %b count %0d expected 0 and %0d", tile_done, tile_count, exp_count); end
        fill_seq(11); acc = 0;
        load_words(H*W, 0);
        drain(-1, 0, 1'b0);
        // Flush in the middle of a drain, after one column has shifted out.
        fill_rand(); acc = 0;
        load_words(H*W, 2);
        col_ready = 1'b1;
        @(posedge clk); #1;
        flush = 1'b1;
        @(negedge clk);
        n_checks++; if ({col_valid, mm_enable, mm_load} !== 3'b000) begin n_fail++; $display("FAIL flush_stream_quiet: valid/enable/load got %b%b%b expected 000", col_valid, mm_enable, mm_load); end
        @(posedge clk); #1;
        flush = 1'b0; col_ready = 1'b0;
        @(negedge clk);
        n_checks++; if ({s_ready, col_valid, tile_done, tile_count} !== {2'b10, 1'b0, exp_count}) begin n_fail++; $display("FAIL flush_stream_state: ready %b valid %b done %b count %0d expected 1 0 0 %0d", s_ready, col_valid, tile_done, tile_count, exp_count); end
        fill_rand(); acc = 0;
        load_words(H*W, 0);
        drain(-1, 0, 1'b0);
    endtask

    task automatic test_reset_stream();
        fill_rand(); acc = 0;
        load_words(H*W, 0);
        col_ready = 1'b1;
        @(posedge clk); #1;
        col_ready = 1'b0;
        #2 reset = 1'b1;
        #1;
        n_checks++; if ({s_ready, col_valid, mm_enable} !== 3'b100) begin n_fail++; $display("FAIL async_reset_outputs: ready/valid/enable got %b%b%b expected 100", s_ready, col_valid, mm_enable); end
        n_checks++; if (tile_count !== 16'd0) begin n_fail++; $display("FAIL async_reset_count: got %0d expected 0", tile_count); end
        @(negedge clk);
        reset = 1'b0;
        exp_count = '0;
        fill_rand(); acc = 0;
        load_words(H*W, 2);
        drain(-1, 0, 1'b1);
    endtask

    task automatic test_random();
        for (int t = 0; t < 8; t++) begin
            fill_rand(); acc = 0;
            load_words(H*W, 2);
            drain(-1, 0, 1'b1);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] w;
        for (int t = 0; t < 65536; t++) begin
            @(posedge clk_s); #1;
            sm_valid = 1'b1; sm_col_ready = 1'b1;
            w = $urandom; sm_data = w;
            @(negedge clk_s);
            n_checks++; if ({sm_load, sm_col_valid, sm_enable} !== 3'b100) begin n_fail++; $display("FAIL wrap_load: load/valid/enable got %b%b%b expected 100 (tile %0d)", sm_load, sm_col_valid, sm_enable, t); end
            @(posedge clk_s); #1;
            sm_valid = 1'b0;
            @(negedge clk_s);
            n_checks++; if ({sm_col_valid, sm_col_last, sm_enable, sm_col_data} !== {3'b110, w}) begin n_fail++; $display("FAIL wrap_column: valid/last/enable %b%b%b data %h expected 110 %h (tile %0d)", sm_col_valid, sm_col_last, sm_enable, sm_col_data, w, t); end
            n_checks++; if (sm_tile_count !== 16'(t)) begin n_fail++; $display("FAIL wrap_count: got %0d expected %0d", sm_tile_count, 16'(t)); end
        end
        @(posedge clk_s); #1;
        sm_col_ready = 1'b0;
        @(negedge clk_s);
        n_checks++; if ({sm_tile_done, sm_tile_count} !== {1'b1, 16'd0}) begin n_fail++; $display("FAIL wrap_final: done %b count %0d expected 1 and 0", sm_tile_done, sm_tile_count); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_valid_toggle();
        test_flush();
        test_reset_stream();
        test_random();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
